// File: rtl/hs_pkg.sv
// Shared types and handshake helpers for valid/ready register stages.
// A transfer happens on a clock edge where both valid and ready are high.
package hs_pkg;

   typedef enum logic [1:0] {
      HS_EMPTY = 2'd0,
      HS_ONE   = 2'd1,
      HS_TWO   = 2'd2
   } hs_state_t;

   function automatic logic hs_in_xfer(input logic vld, input logic rd);
      return vld & rd;
   endfunction

   function automatic logic hs_out_xfer(input logic vld, input logic rd);
      return vld & rd;
   endfunction

endpackage

// File: rtl/hs_skid_reg.sv
// Handshaked register stage with a one-entry skid buffer. Data, valid and ready
// are all driven from flops, so no combinational path crosses the stage.
module hs_skid_reg
   import hs_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din_data,
   input  logic                  din_vld,
   output logic                  din_rd,
   output logic [DATA_WIDTH-1:0] dout_data,
   output logic                  dout_vld,
   input  logic                  dout_rd
);

   hs_state_t             r_state;
   logic [DATA_WIDTH-1:0] r_main;
   logic [DATA_WIDTH-1:0] r_skid;

   hs_state_t             w_state_nxt;
   logic [DATA_WIDTH-1:0] w_main_nxt;
   logic [DATA_WIDTH-1:0] w_skid_nxt;
   logic                  w_din_rd;
   logic                  w_dout_vld;
   logic                  w_in;
   logic                  w_out;

   // Ready depends only on occupancy and reset, never on dout_rd.
   assign w_din_rd   = (r_state != HS_TWO) && !rst;
   assign w_dout_vld = (r_state != HS_EMPTY);
   assign w_in       = hs_in_xfer(din_vld, w_din_rd);
   assign w_out      = hs_out_xfer(w_dout_vld, dout_rd);

   assign din_rd    = w_din_rd;
   assign dout_vld  = w_dout_vld;
   assign dout_data = r_main;

   // Occupancy next-state and storage steering; din_data is only selected on a transfer.
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      case (r_state)
         HS_EMPTY: begin
            if (w_in) begin
               w_main_nxt  = din_data;
               w_state_nxt = HS_ONE;
            end else begin
               w_state_nxt = HS_EMPTY;
            end
         end
         HS_ONE: begin
            if (w_in && w_out) begin
               w_main_nxt  = din_data;
               w_state_nxt = HS_ONE;
            end else if (w_in) begin
               w_skid_nxt  = din_data;
               w_state_nxt = HS_TWO;
            end else if (w_out) begin
               w_state_nxt = HS_EMPTY;
            end else begin
               w_state_nxt = HS_ONE;
            end
         end
         HS_TWO: begin
            // din_rd is low here, so the only event is a drain into main
            if (w_out) begin
               w_main_nxt  = r_skid;
               w_state_nxt = HS_ONE;
            end else begin
               w_state_nxt = HS_TWO;
            end
         end
         default: begin
            w_state_nxt = HS_EMPTY;
         end
      endcase
   end

   // All stage flops, synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= HS_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

endmodule
